hazard_ctrl: RTL and testbench

// - Pipeline hazard sequencer for the 5-stage core. Detects load-use hazards, taken branches in ID and D-memory wait.
// - Drives the PC write enable, the IF/ID write enable and flush, the ID/EX control-bubble select (flush_i of the control-zeroing mux) and the back-end hold.
// - Sits in ID beside the control unit. Pure control, no datapath.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_stat_ctr.sv | 19 +
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard sequencer.
// Used by hazard_ctrl and by hazard_stat_ctr (built only when HAZARD_STATS_EN is defined).
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE,
        LU_STALL
    } hazard_state_t;

    localparam int unsigned LU_STALL_MAX = 7;
    localparam int unsigned CNT3_W       = 3;

endpackage

// File: rtl/hazard_stat_ctr.sv
// Saturating enable counter for hazard statistics (HAZARD_STATS_EN builds only).
module hazard_stat_ctr #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flush, D-memory wait hold.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned REG_AW          = 5,
    parameter int unsigned CNT_W           = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ifid_rs1_i,
    input  logic [REG_AW-1:0] ifid_rs2_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              idex_memread_i,
    input  logic              branch_taken_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_hold_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > LU_STALL_MAX || CNT_W < 1) begin : gBadCfg
        $error("hazard_ctrl: LU_STALL_CYCLES must be 1..7 and CNT_W nonzero");
    end

    hazard_state_t     st, stNext;
    logic [CNT3_W-1:0] cnt, cntNext;
    logic              lu;

    assign lu = idex_memread_i && (idex_rd_i != '0)
             && ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= stNext;
            cnt <= cntNext;
        end
    end

    // Outputs are also gated by rst_i so enables return to 1 while reset is held.
    always_comb begin
        stNext        = st;
        cntNext       = cnt;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (!rst_i) begin
            stNext  = IDLE;
            cntNext = '0;
        end else if (mem_stall_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (st == LU_STALL) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            cntNext       = cnt - 1'b1;
            if (cnt == CNT3_W'(1)) begin
                stNext = IDLE;
            end
        end else if (lu) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                stNext  = LU_STALL;
                cntNext = CNT3_W'(LU_STALL_CYCLES - 1);
            end
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    hazard_stat_ctr #(.CNT_W(CNT_W)) uStallCtr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!pc_write_o),
        .cnt_o (stall_cnt_o)
    );

    hazard_stat_ctr #(.CNT_W(CNT_W)) uFlushCtr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ifid_flush_o),
        .cnt_o (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (1 and 3 bubbles per load-use)
// driven in lockstep and compared each cycle against a bubble-budget reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] rs1, rs2, rd;
    logic       memRead, brTaken, memStall;

    logic        pcW[2], ifidW[2], flushO[2], bubbleO[2], holdO[2];
`ifdef HAZARD_STATS_EN
    logic [31:0] stallC[2], flushC[2];
`endif

    int unsigned tests = 0;
    int unsigned errors = 0;

    // reference model state: bubbles still owed, and expected statistics
    int          owed[2];
    longint      expStall[2], expFlush[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL_CYCLES(1), .REG_AW(5), .CNT_W(32)) uDut1 (
        .clk_i(clk), .rst_i(rst_i),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .idex_rd_i(rd),
        .idex_memread_i(memRead), .branch_taken_i(brTaken), .mem_stall_i(memStall),
        .pc_write_o(pcW[0]), .ifid_write_o(ifidW[0]), .ifid_flush_o(flushO[0]),
        .idex_bubble_o(bubbleO[0]), .pipe_hold_o(holdO[0])
`ifdef HAZARD_STATS_EN
        , .stall_cnt_o(stallC[0]), .flush_cnt_o(flushC[0])
`endif
    );

    hazard_ctrl #(.LU_STALL_CYCLES(3), .REG_AW(5), .CNT_W(32)) uDut3 (
        .clk_i(clk), .rst_i(rst_i),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .idex_rd_i(rd),
        .idex_memread_i(memRead), .branch_taken_i(brTaken), .mem_stall_i(memStall),
        .pc_write_o(pcW[1]), .ifid_write_o(ifidW[1]), .ifid_flush_o(flushO[1]),
        .idex_bubble_o(bubbleO[1]), .pipe_hold_o(holdO[1])
`ifdef HAZARD_STATS_EN
        , .stall_cnt_o(stallC[1]), .flush_cnt_o(flushC[1])
`endif
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive after the falling edge, check 1ns later, advance the model for the next rising edge.
    task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic mr, input logic br, input logic ms);
        @(negedge clk);
        rst_i = rst; rs1 = r1; rs2 = r2; rd = d;
        memRead = mr; brTaken = br; memStall = ms;
        #1;
        for (int k = 0; k < 2; k++) begin
            int          n;
            int          nextOwed;
            logic        hazard;
            logic [4:0]  exp;   // {pcWrite, ifidWrite, flush, bubble, hold}
            logic [4:0]  got;
            n        = (k == 0) ? 1 : 3;
            nextOwed = owed[k];
            hazard   = mr && (d != 0) && ((d == r1) || (d == r2));
            if (!rst) begin
                owed[k] = 0; nextOwed = 0;
                expStall[k] = 0; expFlush[k] = 0;
                exp = 5'b11000;
            end else if (ms) begin
                exp = 5'b00001;
            end else if (owed[k] > 0) begin
                exp = 5'b00010;
                nextOwed = owed[k] - 1;
            end else if (hazard) begin
                exp = 5'b00010;
                nextOwed = n - 1;
            end else if (br) begin
                exp = 5'b11100;
            end else begin
                exp = 5'b11000;
            end
            got = {pcW[k], ifidW[k], flushO[k], bubbleO[k], holdO[k]};
            checkVal((k == 0) ? "outs_n1" : "outs_n3", 64'(got), 64'(exp));
`ifdef HAZARD_STATS_EN
            checkVal((k == 0) ? "stall_n1" : "stall_n3", 64'(stallC[k]), 64'(expStall[k]));
            checkVal((k == 0) ? "flush_n1" : "flush_n3", 64'(flushC[k]), 64'(expFlush[k]));
`endif
            if (rst) begin
                if (!exp[4] && expStall[k] < 64'hFFFF_FFFF) expStall[k]++;
                if (exp[2] && expFlush[k] < 64'hFFFF_FFFF) expFlush[k]++;
            end
            owed[k] = nextOwed;
        end
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        memRead = 1'b0; brTaken = 1'b0; memStall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; expStall[k] = 0; expFlush[k] = 0;
        end

        // reset state, driven with a live hazard to show outputs are forced
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // load x5 in EX, rs1=x5 in ID for one cycle
        step(1'b1, 5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0);
        idle(4);

        // rd=x0 matching rs1=x0: no stall
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        // hazard through rs2
        step(1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        idle(3);

        // taken branch, no hazard
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        idle(1);

        // hazard and branch together: hazard wins, branch held during the stall
        step(1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd4, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd4, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd4, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // memory wait of 4 cycles at the 2nd bubble
        step(1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(4);

        // reset in the middle of a stall
        step(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            logic rr;
            rr = ($urandom_range(0, 99) >= 3);
            step(rr, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
